// File: rtl/alsu_sched_pkg.sv
// Shared types for the ALSU command scheduler: packed command word, opcodes,
// FSM states and the illegal-command filter.
package alsu_sched_pkg;

  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] a;
    logic [2:0] b;
    logic       cin;
    logic       red_op_a;
    logic       red_op_b;
    logic       bypass_a;
    logic       bypass_b;
    logic       direction;
    logic [2:0] cnt;
    logic [5:0] ser;
  } alsu_cmd_t;

  localparam logic [2:0] OP_OR    = 3'b000;
  localparam logic [2:0] OP_XOR   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_SHIFT = 3'b100;
  localparam logic [2:0] OP_ROT   = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SEED,
    S_STEP,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } state_e;

  // Reduction ops are only meaningful for OR/XOR; opcodes 11x do not exist.
  function automatic logic is_illegal(alsu_cmd_t c);
    return (c.opcode[2:1] == 2'b11) ||
           ((c.red_op_a | c.red_op_b) && (c.opcode[2:1] != 2'b00));
  endfunction

endpackage

// File: rtl/alsu_rr_arb2.sv
// Two-way round-robin grant; the pointer only moves when both requesters
// compete, so a lone requester never disturbs the fairness order.
module alsu_rr_arb2 #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_ptr;
  logic w_both;

  assign w_both   = &i_req;
  assign o_gnt[0] = i_en & i_req[0] & (~i_req[1] | ~r_ptr);
  assign o_gnt[1] = i_en & i_req[1] & (~i_req[0] |  r_ptr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= RR_INIT;
    end else if (i_en && w_both) begin
      r_ptr <= ~r_ptr;
    end
  end

endmodule

// File: rtl/alsu_cmd_sched.sv
// Shares one ALSU between two requesters: arbitrates, sequences the ALSU pins
// (single drive or seed + serial shift/rotate steps) and returns a tagged result.
module alsu_cmd_sched
  import alsu_sched_pkg::*;
#(
  parameter bit RR_INIT       = 1'b0,
  parameter bit CHECK_INVALID = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  alsu_cmd_t  req0_cmd,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  alsu_cmd_t  req1_cmd,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [5:0] rsp_result,
  output logic       rsp_err,
  output logic [2:0] alsu_A,
  output logic [2:0] alsu_B,
  output logic [2:0] alsu_opcode,
  output logic       alsu_cin,
  output logic       alsu_serial_in,
  output logic       alsu_red_op_A,
  output logic       alsu_red_op_B,
  output logic       alsu_bypass_A,
  output logic       alsu_bypass_B,
  output logic       alsu_direction,
  input  logic [5:0] alsu_out,
  output logic       busy
);

  state_e    r_state, w_next;
  alsu_cmd_t r_cmd;
  logic      r_id;
  logic [2:0] r_k;
  logic [5:0] r_rsp_result;
  logic      r_rsp_err;

  logic [1:0] w_gnt;
  logic       w_acc;
  logic       w_illegal;
  alsu_cmd_t  w_sel_cmd;
  logic [6:0] w_ser_ext;

  alsu_rr_arb2 #(.RR_INIT(RR_INIT)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_en  (r_state == S_IDLE),
    .i_req ({req1_valid, req0_valid}),
    .o_gnt (w_gnt)
  );

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];
  assign w_acc      = |w_gnt;
  assign w_sel_cmd  = w_gnt[1] ? req1_cmd : req0_cmd;
  assign w_illegal  = CHECK_INVALID && is_illegal(w_sel_cmd);
  // A cnt=7 burst reaches k=6, past the last serial bit; it shifts in 0.
  assign w_ser_ext  = {1'b0, r_cmd.ser};

  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_id     = r_id;
  assign rsp_result = r_rsp_result;
  assign rsp_err    = r_rsp_err;
  assign busy       = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cmd        <= '0;
      r_id         <= 1'b0;
      r_k          <= 3'd0;
      r_rsp_result <= 6'd0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_acc) begin
        r_cmd <= w_sel_cmd;
        r_id  <= w_gnt[1];
        if (w_illegal) begin
          r_rsp_result <= 6'd0;
          r_rsp_err    <= 1'b1;
        end
      end
      if (r_state == S_SEED) r_k <= 3'd0;
      if (r_state == S_STEP) r_k <= r_k + 3'd1;
      if (r_state == S_CAPTURE) begin
        r_rsp_result <= alsu_out;
        r_rsp_err    <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (w_illegal)                          w_next = S_RESP;
          else if (w_sel_cmd.opcode[2:1] == 2'b10) w_next = S_SEED;
          else                                     w_next = S_DRIVE;
        end
      end
      S_DRIVE:   w_next = S_WAIT;
      S_SEED:    w_next = (r_cmd.cnt != 3'd0) ? S_STEP : S_WAIT;
      S_STEP:    if (r_k == r_cmd.cnt - 3'd1) w_next = S_WAIT;
      S_WAIT:    w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_RESP;
      S_RESP:    if (rsp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Outside DRIVE/SEED/STEP the ALSU sees the all-zero idle word.
  always_comb begin
    alsu_A         = 3'd0;
    alsu_B         = 3'd0;
    alsu_opcode    = OP_OR;
    alsu_cin       = 1'b0;
    alsu_serial_in = 1'b0;
    alsu_red_op_A  = 1'b0;
    alsu_red_op_B  = 1'b0;
    alsu_bypass_A  = 1'b0;
    alsu_bypass_B  = 1'b0;
    alsu_direction = 1'b0;
    case (r_state)
      S_DRIVE: begin
        alsu_A         = r_cmd.a;
        alsu_B         = r_cmd.b;
        alsu_opcode    = r_cmd.opcode;
        alsu_cin       = r_cmd.cin;
        alsu_serial_in = r_cmd.ser[0];
        alsu_red_op_A  = r_cmd.red_op_a;
        alsu_red_op_B  = r_cmd.red_op_b;
        alsu_bypass_A  = r_cmd.bypass_a;
        alsu_bypass_B  = r_cmd.bypass_b;
        alsu_direction = r_cmd.direction;
      end
      S_SEED: begin
        alsu_A = r_cmd.a;
        alsu_B = r_cmd.b;
      end
      S_STEP: begin
        alsu_opcode    = r_cmd.opcode;
        alsu_direction = r_cmd.direction;
        alsu_serial_in = w_ser_ext[r_k];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alsu_cmd_sched.sv
// Directed bench for alsu_cmd_sched with a two-stage ALSU stand-in driving alsu_out.
module tb_alsu_cmd_sched;
  import alsu_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  alsu_cmd_t  req0_cmd, req1_cmd;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [5:0] rsp_result;
  logic [2:0] alsu_A, alsu_B, alsu_opcode;
  logic       alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
  logic       alsu_bypass_A, alsu_bypass_B, alsu_direction, busy;
  logic [5:0] alsu_out;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  alsu_cmd_sched #(.RR_INIT(1'b0), .CHECK_INVALID(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
    .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in),
    .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
    .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
    .alsu_direction(alsu_direction), .alsu_out(alsu_out), .busy(busy)
  );

  // ALSU stand-in: pins registered on one edge, out updated on the next.
  logic [2:0] m_a, m_b, m_op;
  logic       m_cin, m_ser, m_ra, m_rb, m_ba, m_bb, m_dir;

  function automatic logic [5:0] alsu_f(input logic [2:0] op, a, b,
      input logic cin, ser, ra, rb, ba, bb, dir, input logic [5:0] cur);
    if (ba) return {3'b0, a};
    if (bb) return {3'b0, b};
    case (op)
      3'd0: return ra ? {5'b0, |a} : rb ? {5'b0, |b} : {3'b0, a | b};
      3'd1: return ra ? {5'b0, ^a} : rb ? {5'b0, ^b} : {3'b0, a ^ b};
      3'd2: return {3'b0, a} + {3'b0, b} + {5'b0, cin};
      3'd3: return {3'b0, a} * {3'b0, b};
      3'd4: return dir ? {cur[4:0], ser} : {ser, cur[5:1]};
      3'd5: return dir ? {cur[4:0], cur[5]} : {cur[0], cur[5:1]};
      default: return 6'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {m_a, m_b, m_op} <= '0;
      {m_cin, m_ser, m_ra, m_rb, m_ba, m_bb, m_dir} <= '0;
      alsu_out <= '0;
    end else begin
      m_a <= alsu_A; m_b <= alsu_B; m_op <= alsu_opcode;
      m_cin <= alsu_cin; m_ser <= alsu_serial_in;
      m_ra <= alsu_red_op_A; m_rb <= alsu_red_op_B;
      m_ba <= alsu_bypass_A; m_bb <= alsu_bypass_B; m_dir <= alsu_direction;
      alsu_out <= alsu_f(m_op, m_a, m_b, m_cin, m_ser, m_ra, m_rb, m_ba, m_bb, m_dir, alsu_out);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic alsu_cmd_t mk(input logic [2:0] op, a, b,
      input logic cin, ra, rb, ba, bb, dir, input logic [2:0] cnt, input logic [5:0] ser);
    alsu_cmd_t c;
    c.opcode = op; c.a = a; c.b = b; c.cin = cin;
    c.red_op_a = ra; c.red_op_b = rb; c.bypass_a = ba; c.bypass_b = bb;
    c.direction = dir; c.cnt = cnt; c.ser = ser;
    return c;
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Offers one command; the accept cycle is cycle 0, returns at drive point of cycle 1.
  task automatic send(input int id, input alsu_cmd_t c, input string tag);
    if (id == 0) begin req0_valid = 1'b1; req0_cmd = c; end
    else         begin req1_valid = 1'b1; req1_cmd = c; end
    @(negedge clk);
    check({tag, "_ready"}, (id == 0) ? req0_ready : req1_ready, 1);
    adv();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic grab(input int exp_id, input string tag);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (req0_ready | req1_ready) seen = 1;
      else adv();
    end
    check({tag, "_granted"}, seen, 1);
    if (seen) check({tag, "_gnt"}, {req1_ready, req0_ready}, (exp_id == 1) ? 2 : 1);
    adv();
  endtask

  // Called at the drive point of cycle c0 (cycles counted from the accept).
  task automatic wait_rsp(input int c0, input int lat, input int id, input logic [5:0] res,
                          input logic err, input int hold, input string tag);
    int  n = c0;
    bit  seen = 0;
    while (!seen && n < c0 + 30) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
      else begin adv(); n++; end
    end
    check({tag, "_rsp_seen"}, seen, 1);
    if (seen) begin
      check({tag, "_latency"}, n, lat);
      check({tag, "_id"}, rsp_id, id);
      check({tag, "_result"}, rsp_result, res);
      check({tag, "_err"}, rsp_err, err);
      check({tag, "_idle_op"}, alsu_opcode, 0);
      for (int h = 0; h < hold; h++) begin
        adv();
        @(negedge clk);
        check({tag, "_hold_valid"}, rsp_valid, 1);
        check({tag, "_hold_result"}, rsp_result, res);
        check({tag, "_hold_id"}, rsp_id, id);
      end
      rsp_ready = 1'b1;
      adv();
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_cmd = '0; req1_cmd = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_opcode", alsu_opcode, 0);
    check("rst_result", rsp_result, 0);
    adv();
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready0", req0_ready, 0);
    adv();

    // Single ADD: 1 + 2 + cin = 4
    send(0, mk(OP_ADD, 3'd1, 3'd2, 1, 0, 0, 0, 0, 0, 3'd0, 6'd0), "add");
    @(negedge clk);
    check("add_opcode", alsu_opcode, 3'b010);
    check("add_A", alsu_A, 1);
    check("add_B", alsu_B, 2);
    check("add_cin", alsu_cin, 1);
    check("add_busy", busy, 1);
    adv();
    wait_rsp(2, 4, 0, 6'd4, 0, 0, "add");
    @(negedge clk);
    check("add_after_valid", rsp_valid, 0);
    check("add_after_busy", busy, 0);
    adv();

    // Shift-load left: seed 000011, shift in 1 then 0 -> 001110
    send(1, mk(OP_SHIFT, 3'd3, 3'd0, 0, 0, 0, 0, 0, 1, 3'd2, 6'b000001), "shl");
    @(negedge clk);
    check("shl_seed_op", alsu_opcode, 0);
    check("shl_seed_A", alsu_A, 3);
    adv();
    @(negedge clk);
    check("shl_step1_op", alsu_opcode, 3'b100);
    check("shl_step1_ser", alsu_serial_in, 1);
    check("shl_step1_dir", alsu_direction, 1);
    adv();
    @(negedge clk);
    check("shl_step2_ser", alsu_serial_in, 0);
    check("shl_step2_op", alsu_opcode, 3'b100);
    adv();
    wait_rsp(4, 6, 1, 6'b001110, 0, 0, "shl");

    // cnt=0 returns the seed 5|2
    send(0, mk(OP_SHIFT, 3'd5, 3'd2, 0, 0, 0, 0, 0, 0, 3'd0, 6'd0), "cnt0");
    wait_rsp(1, 4, 0, 6'd7, 0, 0, "cnt0");
    // rotate right x3 of 000101 -> 101000
    send(1, mk(OP_ROT, 3'd1, 3'd4, 0, 0, 0, 0, 0, 0, 3'd3, 6'd0), "rotr");
    wait_rsp(1, 7, 1, 6'd40, 0, 0, "rotr");
    // shift right x1 of 0 with ser 1 -> 100000
    send(0, mk(OP_SHIFT, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 3'd1, 6'b000001), "shr");
    wait_rsp(1, 5, 0, 6'd32, 0, 0, "shr");
    // cnt=7: six ones then a zero -> 111110
    send(1, mk(OP_SHIFT, 3'd0, 3'd0, 0, 0, 0, 0, 0, 1, 3'd7, 6'b111111), "cnt7");
    wait_rsp(1, 11, 1, 6'd62, 0, 0, "cnt7");
    send(0, mk(OP_MUL, 3'd7, 3'd7, 0, 0, 0, 0, 0, 0, 3'd0, 6'd0), "mul");
    wait_rsp(1, 4, 0, 6'd49, 0, 0, "mul");
    send(1, mk(OP_XOR, 3'd6, 3'd3, 0, 0, 0, 0, 0, 0, 3'd0, 6'd0), "xor");
    wait_rsp(1, 4, 1, 6'd5, 0, 0, "xor");
    send(0, mk(OP_ADD, 3'd5, 3'd1, 0, 0, 0, 1, 0, 0, 3'd0, 6'd0), "byp");
    wait_rsp(1, 4, 0, 6'd5, 0, 0, "byp");
    send(0, mk(OP_OR, 3'd2, 3'd0, 0, 1, 0, 0, 0, 0, 3'd0, 6'd0), "redor");
    wait_rsp(1, 4, 0, 6'd1, 0, 0, "redor");

    // Illegal commands
    send(0, mk(3'b110, 3'd7, 3'd7, 0, 0, 0, 0, 0, 0, 3'd0, 6'd0), "ill_op");
    wait_rsp(1, 1, 0, 6'd0, 1, 0, "ill_op");
    send(0, mk(OP_ADD, 3'd1, 3'd1, 0, 1, 0, 0, 0, 0, 3'd0, 6'd0), "ill_red");
    wait_rsp(1, 1, 0, 6'd0, 1, 0, "ill_red");

    // Contention: req0 ADD 1+1=2, req1 XOR 5^3=6, both held valid
    req0_cmd = mk(OP_ADD, 3'd1, 3'd1, 0, 0, 0, 0, 0, 0, 3'd0, 6'd0);
    req1_cmd = mk(OP_XOR, 3'd5, 3'd3, 0, 0, 0, 0, 0, 0, 3'd0, 6'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      grab(k % 2, $sformatf("rr%0d", k));
      if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      wait_rsp(1, 4, k % 2, (k % 2) ? 6'd6 : 6'd2, 0, (k == 0) ? 3 : 0, $sformatf("rr%0d", k));
    end

    // Reset during the 2nd STEP of a cnt=5 rotate
    send(0, mk(OP_ROT, 3'd3, 3'd0, 0, 0, 0, 0, 0, 1, 3'd5, 6'b000010), "mid");
    adv();
    @(negedge clk);
    check("mid_step1_op", alsu_opcode, 3'b101);
    adv();
    @(negedge clk);
    check("mid_step2_dir", alsu_direction, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_op", alsu_opcode, 0);
    check("mid_rst_A", alsu_A, 0);
    check("mid_rst_dir", alsu_direction, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", rsp_valid, 0);
    adv();
    rst = 1'b0;
    send(1, mk(OP_OR, 3'd4, 3'd1, 0, 0, 0, 0, 0, 0, 3'd0, 6'd0), "post");
    wait_rsp(1, 4, 1, 6'd5, 0, 0, "post");
    req0_cmd = mk(OP_OR, 3'd1, 3'd2, 0, 0, 0, 0, 0, 0, 3'd0, 6'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    grab(0, "prio");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(1, 4, 0, 6'd3, 0, 0, "prio");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alsu_cmd_sched.md
Name: alsu_cmd_sched

Overview:
- Round-robin command scheduler sharing one ALSU datapath between two requesters.
- Accepts packed commands over valid/ready and drives the ALSU input pins cycle-by-cycle.
- Sequences multi-cycle shift/rotate bursts, including a seed cycle and serial bits, then captures the ALSU output and returns a tagged response.
- Filters illegal opcode/flag combinations before they reach the datapath.

Parameters:
- RR_INIT, 0: requester that has priority after reset.
- CHECK_INVALID, 1: 1 = illegal commands are rejected locally with err; 0 = they are forwarded to the ALSU and the captured result is returned with err=0.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  command valid
- req0_ready / req1_ready  out  1  command accepted this cycle
- req0_cmd / req1_cmd  in  24  alsu_cmd_t
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_id  out  1  requester that issued the command
- rsp_result  out  6  captured ALSU out
- rsp_err  out  1  command rejected as illegal
- alsu_A, alsu_B  out  3 each  ALSU operands
- alsu_opcode  out  3  ALSU opcode
- alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction  out  1 each  ALSU controls
- alsu_out  in  6  ALSU result
- busy  out  1  state != IDLE

Behaviour:
- Reset: async, active-high, effective mid-operation. State -> IDLE, rr pointer -> RR_INIT, all outputs 0, any in-flight command is discarded.
- Idle word: every ALSU output is 0 (opcode 000, A=B=0). It is driven in every state except DRIVE, SEED and STEP.
- ALSU timing: inputs are registered at edge e1, out is updated at e2. A drive in cycle t is readable on alsu_out in cycle t+2.
- Arbitration (IDLE only):
  - Grant the single valid requester.
  - If both are valid, grant the one the pointer selects, then move the pointer to the other requester.
  - reqN_ready = (state==IDLE) & grantN; it is combinational from valid. The accepted command is latched on that edge.
- Illegal command (CHECK_INVALID=1): opcode 11x, or red_op_a|red_op_b with opcode[2:1]!=00. Go directly to RESP with err=1, result=0 and no ALSU drive.
- FSM states: IDLE, DRIVE, SEED, STEP, WAIT, CAPTURE, RESP.
  - IDLE -> DRIVE if opcode is 0xx and legal.
  - IDLE -> SEED if opcode is 10x and legal.
  - IDLE -> RESP if the command is illegal.
  - DRIVE (1 cycle): drive all command fields; serial_in=ser[0]. -> WAIT.
  - SEED (1 cycle): opcode 000, A/B from the command, all flags 0, so out = A|B. step counter k=0. -> STEP if cnt!=0, else WAIT.
  - STEP (cnt cycles): drive the command opcode and direction, serial_in=ser[k], other flags 0, k++. -> WAIT when k==cnt-1.
  - WAIT (1 cycle) -> CAPTURE.
  - CAPTURE: rsp_result <= alsu_out, rsp_err <= 0. -> RESP.
  - RESP: rsp_valid=1. rsp_id/result/err are held stable until rsp_valid & rsp_ready, then -> IDLE. A new grant is possible in the next cycle.
- Latency from the accept edge to rsp_valid:
  - opcodes 0–3: 4 cycles.
  - shift/rotate: 4+cnt cycles.
  - illegal: 1 cycle.
- cnt=0 returns the seed value. cnt ranges 1..7; ser[6] is never used.
- Requests arriving while busy stay pending; valid must be held by the requester and ready stays 0.

Decomposition:
- Package alsu_sched_pkg:
  - alsu_cmd_t packed struct, MSB->LSB: opcode[2:0], a[2:0], b[2:0], cin, red_op_a, red_op_b, bypass_a, bypass_b, direction, cnt[2:0], ser[5:0] (24 bits).
  - Opcode constants OP_OR, OP_XOR, OP_ADD, OP_MUL, OP_SHIFT, OP_ROT.
  - state_e enum.
  - is_illegal() function.
- Sub-module: alsu_rr_arb2, holding the 2-way round-robin grant and pointer.

Test Plan:
- Single ADD: req0 {opcode 010, A=3'b001, B=3'b010, cin=1}. Expect ready in cycle 0; alsu_opcode=010 in cycle 1; rsp_valid in cycle 4 with result 6'b000100, id=0, err=0.
- Shift-load: req1 {opcode 100, A=011, B=000, direction=1, cnt=2, ser=6'b000001}. Expect serial_in 1 then 0 on STEP; rsp_result 6'b001110, id=1, rsp_valid 6 cycles after accept.
- Contention: req0 and req1 held valid continuously. Expect grants 0,1,0,1 (RR_INIT=0); each response is held until rsp_ready, with back-pressure of 3 cycles on the first response.
- Illegal: req0 {opcode 110} and then {opcode 010, red_op_a=1}. Expect rsp_valid 1 cycle after accept with err=1, result=0, and alsu_opcode staying 000 throughout.
- Reset mid-STEP of a cnt=5 rotate: assert rst in the 2nd STEP. Expect all ALSU outputs, rsp_valid and busy at 0 immediately; after release, a new req1 command is granted first only if req0 is idle.
